// File: rtl/riscv_pkg.sv
// Shared core definitions: machine-timer register map used by the bus
// decoder, the timer itself and the software headers.
package riscv_pkg;

   localparam logic [2:0] MTIMER_OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] MTIMER_OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] MTIMER_OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] MTIMER_OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] MTIMER_OFF_CTRL        = 3'd4;

   localparam int unsigned MTIMER_WIN_BYTES = 32;

   // Every 3-bit offset has a label so a cast from the address is total.
   typedef enum logic [2:0] {
      MTIMER_REG_MTIME_LO    = MTIMER_OFF_MTIME_LO,
      MTIMER_REG_MTIME_HI    = MTIMER_OFF_MTIME_HI,
      MTIMER_REG_MTIMECMP_LO = MTIMER_OFF_MTIMECMP_LO,
      MTIMER_REG_MTIMECMP_HI = MTIMER_OFF_MTIMECMP_HI,
      MTIMER_REG_CTRL        = MTIMER_OFF_CTRL,
      MTIMER_REG_RSVD5       = 3'd5,
      MTIMER_REG_RSVD6       = 3'd6,
      MTIMER_REG_RSVD7       = 3'd7
   } mtimer_reg_e;

   localparam int unsigned MTIMER_CTRL_EN_BIT = 0;

endpackage

// File: rtl/mtimer_if.sv
// Data-memory port between the core (master) and a memory-mapped
// responder such as the machine timer (slave).
interface mtimer_if;

   logic [31:0] addr_i;
   logic        read_i;
   logic [3:0]  wsel_byte_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        hit_o;

   modport master (
      output addr_i,
      output read_i,
      output wsel_byte_i,
      output wdata_i,
      input  rdata_o,
      input  hit_o
   );

   modport slave (
      input  addr_i,
      input  read_i,
      input  wsel_byte_i,
      input  wdata_i,
      output rdata_o,
      output hit_o
   );

endinterface

// File: rtl/mtimer_prescaler.sv
// Divides the clock into mtime increment ticks; one tick every PRESCALE
// enabled cycles, holding its count while disabled.
module mtimer_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic en_i,
   output logic tick_o
);

   generate
      if (PRESCALE <= 1) begin : g_direct
         logic unused_clk_rst;
         assign unused_clk_rst = clk_i ^ rstn_i;
         assign tick_o         = en_i;
      end else begin : g_count
         localparam int W = $clog2(PRESCALE);
         localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

         logic [W-1:0] cnt_q;
         logic [W-1:0] cnt_d;
         logic         wrap;

         assign wrap = (cnt_q == LAST);

         always_comb begin
            cnt_d = cnt_q;
            if (en_i) begin
               cnt_d = wrap ? '0 : cnt_q + W'(1);
            end
         end

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign tick_o = en_i & wrap;
      end
   endgenerate

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp plus CTRL behind a 32-byte
// window on the data bus, with a registered level interrupt.
module mtimer
   import riscv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic    clk_i,
   input  logic    rstn_i,
   mtimer_if.slave bus,
   output logic    timer_irq_o
);

   logic        hit;
   logic        wr;
   logic        tick;
   mtimer_reg_e sel;
   logic [31:0] rdata;
   logic [1:0]  unused_addr;

   logic [63:0] mtime_q;
   logic [63:0] mtime_d;
   logic [63:0] mtimecmp_q;
   logic [63:0] mtimecmp_d;
   logic        en_q;
   logic        en_d;
   logic        irq_q;
   logic        irq_d;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  lanes
   );
      logic [31:0] r;
      r = old_v;
      for (int k = 0; k < 4; k++) begin
         if (lanes[k]) begin
            r[8*k +: 8] = new_v[8*k +: 8];
         end
      end
      return r;
   endfunction

   assign hit         = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
   assign sel         = mtimer_reg_e'(bus.addr_i[4:2]);
   assign wr          = hit & (|bus.wsel_byte_i);
   assign unused_addr = bus.addr_i[1:0];

   mtimer_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .en_i  (en_q),
      .tick_o(tick)
   );

   // A bus write to either mtime half overrides the whole increment.
   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      en_d       = en_q;
      if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
      if (wr) begin
         case (sel)
            MTIMER_REG_MTIME_LO: begin
               mtime_d = {mtime_q[63:32],
                          lane_merge(mtime_q[31:0], bus.wdata_i,
                                     bus.wsel_byte_i)};
            end
            MTIMER_REG_MTIME_HI: begin
               mtime_d = {lane_merge(mtime_q[63:32], bus.wdata_i,
                                     bus.wsel_byte_i),
                          mtime_q[31:0]};
            end
            MTIMER_REG_MTIMECMP_LO: begin
               mtimecmp_d = {mtimecmp_q[63:32],
                             lane_merge(mtimecmp_q[31:0], bus.wdata_i,
                                        bus.wsel_byte_i)};
            end
            MTIMER_REG_MTIMECMP_HI: begin
               mtimecmp_d = {lane_merge(mtimecmp_q[63:32], bus.wdata_i,
                                        bus.wsel_byte_i),
                             mtimecmp_q[31:0]};
            end
            MTIMER_REG_CTRL: begin
               if (bus.wsel_byte_i[0]) begin
                  en_d = bus.wdata_i[MTIMER_CTRL_EN_BIT];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign irq_d = (mtime_q >= mtimecmp_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         en_q       <= 1'b1;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         MTIMER_REG_MTIME_LO:    rdata = mtime_q[31:0];
         MTIMER_REG_MTIME_HI:    rdata = mtime_q[63:32];
         MTIMER_REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
         MTIMER_REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
         MTIMER_REG_CTRL:        rdata = {31'b0, en_q};
         default:                rdata = '0;
      endcase
   end

   assign bus.rdata_o = (hit & bus.read_i) ? rdata : 32'h0;
   assign bus.hit_o   = hit;
   assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: one instance at PRESCALE=1, one at PRESCALE=4,
// driven through the data-port interface.
module tb_mtimer;
   import riscv_pkg::*;

   localparam logic [31:0] BASE = 32'h0002_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn1;
   logic rstn4;
   logic irq1;
   logic irq4;

   mtimer_if bus1 ();
   mtimer_if bus4 ();

   mtimer #(
      .BASE_ADDR(BASE),
      .PRESCALE (1)
   ) u_dut1 (
      .clk_i      (clk),
      .rstn_i     (rstn1),
      .bus        (bus1),
      .timer_irq_o(irq1)
   );

   mtimer #(
      .BASE_ADDR(BASE),
      .PRESCALE (4)
   ) u_dut4 (
      .clk_i      (clk),
      .rstn_i     (rstn4),
      .bus        (bus4),
      .timer_irq_o(irq4)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       nm;
      logic [31:0] rdata;
      logic        hit;
   } exp_t;

   typedef struct {
      string       nm;
      logic [31:0] addr;
      logic        rd;
      logic [3:0]  wsel;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        hit;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[18];

   function automatic logic [31:0] ra(input logic [2:0] off);
      return BASE | {27'b0, off, 2'b00};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic idle_all();
      bus1.addr_i      = 32'h0;
      bus1.read_i      = 1'b0;
      bus1.wsel_byte_i = 4'h0;
      bus1.wdata_i     = 32'h0;
      bus4.addr_i      = 32'h0;
      bus4.read_i      = 1'b0;
      bus4.wsel_byte_i = 4'h0;
      bus4.wdata_i     = 32'h0;
   endtask

   // One bus cycle: drive at negedge, check, let the posedge commit it.
   task automatic step(input bit d4, input string nm,
                       input logic [31:0] a, input logic rd,
                       input logic [3:0] ws, input logic [31:0] wd,
                       input logic [31:0] er, input logic eh);
      exp_t e;
      logic [31:0] got_r;
      logic        got_h;
      @(negedge clk);
      idle_all();
      if (d4) begin
         bus4.addr_i      = a;
         bus4.read_i      = rd;
         bus4.wsel_byte_i = ws;
         bus4.wdata_i     = wd;
      end else begin
         bus1.addr_i      = a;
         bus1.read_i      = rd;
         bus1.wsel_byte_i = ws;
         bus1.wdata_i     = wd;
      end
      exp_q.push_back('{nm, er, eh});
      #2;
      e     = exp_q.pop_front();
      got_r = d4 ? bus4.rdata_o : bus1.rdata_o;
      got_h = d4 ? bus4.hit_o : bus1.hit_o;
      chk({e.nm, ".rdata"}, got_r, e.rdata);
      chk({e.nm, ".hit"}, {31'b0, got_h}, {31'b0, e.hit});
      @(posedge clk);
      #1;
      idle_all();
   endtask

   task automatic wr1(input string nm, input logic [2:0] off,
                      input logic [31:0] wd);
      step(1'b0, nm, ra(off), 1'b0, 4'hF, wd, 32'h0, 1'b1);
   endtask

   task automatic rd1(input string nm, input logic [2:0] off,
                      input logic [31:0] er);
      step(1'b0, nm, ra(off), 1'b1, 4'h0, 32'h0, er, 1'b1);
   endtask

   initial begin
      vecs[0]  = '{"cmp_lo_rst", ra(3'd2), 1, 4'h0, 32'h0, 32'hFFFF_FFFF, 1};
      vecs[1]  = '{"cmp_hi_rst", ra(3'd3), 1, 4'h0, 32'h0, 32'hFFFF_FFFF, 1};
      vecs[2]  = '{"ctrl_rst", ra(3'd4), 1, 4'h0, 32'h0, 32'h1, 1};
      vecs[3]  = '{"rsvd5_rd", ra(3'd5), 1, 4'h0, 32'h0, 32'h0, 1};
      vecs[4]  = '{"rsvd6_wr", ra(3'd6), 0, 4'hF, 32'hDEAD_BEEF, 32'h0, 1};
      vecs[5]  = '{"rsvd6_rd", ra(3'd6), 1, 4'h0, 32'h0, 32'h0, 1};
      vecs[6]  = '{"rsvd7_rd", ra(3'd7), 1, 4'h0, 32'h0, 32'h0, 1};
      vecs[7]  = '{"oow_rd", BASE + 32, 1, 4'h0, 32'h0, 32'h0, 0};
      vecs[8]  = '{"cmp_lo_wr", ra(3'd2), 0, 4'hF, 32'h1122_3344, 32'h0, 1};
      vecs[9]  = '{"cmp_lo_rd", ra(3'd2), 1, 4'h0, 32'h0, 32'h1122_3344, 1};
      vecs[10] = '{"lane2_wr", ra(3'd2), 0, 4'b0100, 32'h00AA_0000, 32'h0, 1};
      vecs[11] = '{"lane2_rd", ra(3'd2) | 32'h3, 1, 4'h0, 32'h0, 32'h11AA_3344, 1};
      vecs[12] = '{"oow_wr", BASE + 40, 0, 4'hF, 32'h0, 32'h0, 0};
      vecs[13] = '{"rw_same", ra(3'd2), 1, 4'hF, 32'hCAFE_0000, 32'h11AA_3344, 1};
      vecs[14] = '{"rw_after", ra(3'd2), 1, 4'h0, 32'h0, 32'hCAFE_0000, 1};
      vecs[15] = '{"cmp_hi_keep", ra(3'd3), 1, 4'h0, 32'h0, 32'hFFFF_FFFF, 1};
      vecs[16] = '{"ctrl_lane1", ra(3'd4), 0, 4'b0010, 32'h0, 32'h0, 1};
      vecs[17] = '{"ctrl_keep", ra(3'd4), 1, 4'h0, 32'h0, 32'h1, 1};

      idle_all();
      rstn1 = 1'b0;
      rstn4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("irq_in_rst", {31'b0, irq1}, 32'h0);
      rstn1 = 1'b1;

      rd1("mtime_lo_rst", 3'd0, 32'h0);
      chk("irq_after_rst", {31'b0, irq1}, 32'h0);
      step(1'b0, "idle_rdata", ra(3'd2), 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

      foreach (vecs[i]) begin
         step(1'b0, vecs[i].nm, vecs[i].addr, vecs[i].rd, vecs[i].wsel,
              vecs[i].wdata, vecs[i].rdata, vecs[i].hit);
      end

      // 64-bit carry, then write/tick collisions on each half.
      wr1("wr_hi0", 3'd1, 32'h0);
      wr1("wr_lo", 3'd0, 32'hFFFF_FFFE);
      rd1("carry_lo0", 3'd0, 32'hFFFF_FFFE);
      rd1("carry_lo1", 3'd0, 32'hFFFF_FFFF);
      rd1("carry_hi", 3'd1, 32'h1);
      rd1("carry_lo2", 3'd0, 32'h1);
      wr1("coll_lo_wr", 3'd0, 32'h100);
      rd1("coll_lo", 3'd0, 32'h100);
      rd1("coll_lo_hi", 3'd1, 32'h1);
      wr1("coll_hi_wr", 3'd1, 32'h5);
      rd1("coll_hi_lo", 3'd0, 32'h102);
      rd1("coll_hi", 3'd1, 32'h5);

      // Interrupt at mtimecmp = 20.
      wr1("cmp_lo20", 3'd2, 32'd20);
      wr1("cmp_hi0", 3'd3, 32'h0);
      wr1("mt_hi0", 3'd1, 32'h0);
      wr1("mt_lo0", 3'd0, 32'h0);
      for (int j = 0; j < 25; j++) begin
         rd1($sformatf("irq_mt%0d", j), 3'd0, j);
         chk($sformatf("irq_at%0d", j), {31'b0, irq1}, {31'b0, j >= 20});
      end
      wr1("cmp_hi1", 3'd3, 32'h1);
      chk("irq_hold", {31'b0, irq1}, 32'h1);
      @(posedge clk);
      #1;
      chk("irq_fall", {31'b0, irq1}, 32'h0);
      wr1("cmp_hi0b", 3'd3, 32'h0);
      chk("irq_low", {31'b0, irq1}, 32'h0);
      @(posedge clk);
      #1;
      chk("irq_rise", {31'b0, irq1}, 32'h1);

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #2;
      rstn1 = 1'b0;
      #1;
      chk("irq_async_rst", {31'b0, irq1}, 32'h0);
      bus1.addr_i = ra(3'd3);
      bus1.read_i = 1'b1;
      #1;
      chk("cmp_hi_async_rst", bus1.rdata_o, 32'hFFFF_FFFF);
      bus1.addr_i = ra(3'd1);
      #1;
      chk("mt_hi_async_rst", bus1.rdata_o, 32'h0);
      idle_all();
      rstn1 = 1'b1;

      // Prescaler of 4 from a fresh reset.
      @(negedge clk);
      rstn4 = 1'b1;
      repeat (3) @(posedge clk);
      step(1'b1, "ps_mt0", ra(3'd0), 1'b1, 4'h0, 32'h0, 32'd0, 1'b1);
      repeat (7) @(posedge clk);
      step(1'b1, "ps_mt2", ra(3'd0), 1'b1, 4'h0, 32'h0, 32'd2, 1'b1);
      step(1'b1, "ps_mt3", ra(3'd0), 1'b1, 4'h0, 32'h0, 32'd3, 1'b1);
      step(1'b1, "ps_en0", ra(3'd4), 1'b0, 4'h1, 32'h0, 32'h0, 1'b1);
      repeat (10) @(posedge clk);
      step(1'b1, "ps_hold", ra(3'd0), 1'b1, 4'h0, 32'h0, 32'd3, 1'b1);
      step(1'b1, "ps_ctrl", ra(3'd4), 1'b1, 4'h0, 32'h0, 32'h0, 1'b1);
      chk("ps_irq", {31'b0, irq4}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errors);
      $finish;
   end

endmodule
